// File: rtl/ama_riscv_hazard_unit.sv
// ama_riscv_hazard_unit
//   Pipeline hazard control for a 5-stage RISC-V core. Tracks the destination
//   and type of the instruction in EX, and from that plus the ID operands,
//   the branch outcome and data-memory handshake it decides stalls, bubbles
//   and flushes. It also counts stall cycles.
//
// Ports
//   clk, rst_n           : clock, synchronous active-low reset
//   rs1_id/rs2_id        : ID source indices, qualified by rs*_used_id
//   rd_id, reg_we_id     : ID destination and its write enable
//   load_inst_id         : ID instruction is a load
//   mem_inst_id          : ID instruction is a load or store
//   branch_taken_ex      : EX instruction redirects the PC
//   dmem_ready           : data memory accepts/completes the EX access
//   rd_ex, reg_we_ex     : tracked EX destination (to forwarding logic)
//   stall_if, stall_id   : hold PC / hold IF-ID register
//   bubble_ex            : insert a NOP into EX on the next edge
//   flush_id             : kill the ID instruction
//   stall_cnt            : saturating count of cycles with stall_if high
module ama_riscv_hazard_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        rs1_used_id,
  input  logic        rs2_used_id,
  input  logic [4:0]  rd_id,
  input  logic        reg_we_id,
  input  logic        load_inst_id,
  input  logic        mem_inst_id,
  input  logic        branch_taken_ex,
  input  logic        dmem_ready,
  output logic [4:0]  rd_ex,
  output logic        reg_we_ex,
  output logic        stall_if,
  output logic        stall_id,
  output logic        bubble_ex,
  output logic        flush_id,
  output logic [15:0] stall_cnt
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic       load;
    logic       mem;
  } ex_t;

  state_t state, state_nxt;
  ex_t    ex_q, ex_d;
  logic   mem_busy, rs1_hit, rs2_hit, load_use;

  assign rd_ex     = ex_q.rd;
  assign reg_we_ex = ex_q.we;

  // The EX memory access is still outstanding; mem_ex stays set through
  // MEM_WAIT because the tracking registers are frozen by stall_id.
  assign mem_busy = ex_q.mem & ~dmem_ready;

  assign rs1_hit  = rs1_used_id & (rs1_id == ex_q.rd);
  assign rs2_hit  = rs2_used_id & (rs2_id == ex_q.rd);
  // rd_ex != 0 also covers a zero source index: a hit on x0 needs rd_ex == 0.
  assign load_use = (state == RUN) & ex_q.load & ex_q.we &
                    (ex_q.rd != 5'd0) & (rs1_hit | rs2_hit);

  // Control outputs and next state. Memory wait beats branch beats load-use;
  // a branch seen while waiting is only acted on once dmem_ready arrives.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    state_nxt = state;
    if (!rst_n) begin
      bubble_ex = 1'b1;
      state_nxt = RUN;
    end else begin
      if (mem_busy) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
      end else if (branch_taken_ex) begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (load_use) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
      case (state)
        RUN:      if (mem_busy)   state_nxt = MEM_WAIT;
        MEM_WAIT: if (dmem_ready) state_nxt = RUN;
        default:                  state_nxt = RUN;
      endcase
    end
  end

  // EX tracking: a bubble clears it, an ID stall (which covers every
  // waiting cycle of MEM_WAIT) holds it, otherwise it follows ID.
  always_comb begin
    ex_d = ex_q;
    if (bubble_ex)
      ex_d = '0;
    else if (!stall_id)
      ex_d = '{rd: rd_id, we: reg_we_id, load: load_inst_id, mem: mem_inst_id};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      ex_q      <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      ex_q  <= ex_d;
      if (stall_if && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ama_riscv_hazard_unit.sv
// Self-checking bench for ama_riscv_hazard_unit: a directed vector table,
// a randomized run against a behavioural model, and a long stall run for
// counter saturation followed by a reset in the middle of a memory wait.
module tb_ama_riscv_hazard_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_id, rs2_id, rd_id;
  logic        rs1_used_id, rs2_used_id, reg_we_id, load_inst_id, mem_inst_id;
  logic        branch_taken_ex, dmem_ready;
  logic [4:0]  rd_ex;
  logic        reg_we_ex, stall_if, stall_id, bubble_ex, flush_id;
  logic [15:0] stall_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ama_riscv_hazard_unit dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_id(rd_id), .reg_we_id(reg_we_id),
    .load_inst_id(load_inst_id), .mem_inst_id(mem_inst_id),
    .branch_taken_ex(branch_taken_ex), .dmem_ready(dmem_ready),
    .rd_ex(rd_ex), .reg_we_ex(reg_we_ex),
    .stall_if(stall_if), .stall_id(stall_id),
    .bubble_ex(bubble_ex), .flush_id(flush_id),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic        r;
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [4:0]  rd;
    logic        we, ld, mem, br, rdy;
    logic        sif, sid, bub, fl;
    logic [4:0]  rdex;
    logic        weex;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t v(input int r, rs1, rs2, u1, u2, rd, we, ld, mem,
                             br, rdy, sif, sid, bub, fl, rdex, weex, cnt);
    vec_t t;
    t.r = 1'(r); t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.u1 = 1'(u1); t.u2 = 1'(u2);
    t.rd = 5'(rd); t.we = 1'(we); t.ld = 1'(ld); t.mem = 1'(mem);
    t.br = 1'(br); t.rdy = 1'(rdy);
    t.sif = 1'(sif); t.sid = 1'(sid); t.bub = 1'(bub); t.fl = 1'(fl);
    t.rdex = 5'(rdex); t.weex = 1'(weex); t.cnt = 16'(cnt);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    else passed++;
  endtask

  task automatic chk_all(input string tag, input logic sif, sid, bub, fl,
                         input logic [4:0] rdex, input logic weex, input logic [15:0] cnt);
    chk({tag, ".stall_if"},  32'(stall_if),  32'(sif));
    chk({tag, ".stall_id"},  32'(stall_id),  32'(sid));
    chk({tag, ".bubble_ex"}, 32'(bubble_ex), 32'(bub));
    chk({tag, ".flush_id"},  32'(flush_id),  32'(fl));
    chk({tag, ".rd_ex"},     32'(rd_ex),     32'(rdex));
    chk({tag, ".reg_we_ex"}, 32'(reg_we_ex), 32'(weex));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(cnt));
  endtask

  // ---------------- behavioural model ----------------
  // Instruction occupying EX, whether its memory access is pending, and
  // the number of stalled fetch cycles seen so far.
  bit       m_wait;
  bit [4:0] m_rd;
  bit       m_we, m_ld, m_mem;
  int       m_cnt;
  bit       e_sif, e_sid, e_bub, e_fl, e_busy;

  function automatic void model_eval();
    bit dep;
    e_sif = 0; e_sid = 0; e_bub = 0; e_fl = 0;
    e_busy = m_mem && !dmem_ready;
    dep = m_ld && m_we && (m_rd != 0) &&
          ((rs1_used_id && rs1_id == m_rd) || (rs2_used_id && rs2_id == m_rd));
    if (!rst_n)               e_bub = 1;
    else if (e_busy)          begin e_sif = 1; e_sid = 1; end
    else if (branch_taken_ex) begin e_fl = 1; e_bub = 1; end
    else if (!m_wait && dep)  begin e_sif = 1; e_sid = 1; e_bub = 1; end
  endfunction

  function automatic void model_step();
    model_eval();
    if (!rst_n) begin
      m_wait = 0; m_rd = 0; m_we = 0; m_ld = 0; m_mem = 0; m_cnt = 0;
    end else begin
      if (e_sif) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
      if (e_bub) begin
        m_rd = 0; m_we = 0; m_ld = 0; m_mem = 0;
      end else if (!e_sid) begin
        m_rd = rd_id; m_we = reg_we_id; m_ld = load_inst_id; m_mem = mem_inst_id;
      end
      m_wait = e_busy;  // waiting continues exactly while the access is pending
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input vec_t t);
    rst_n = t.r; rs1_id = t.rs1; rs2_id = t.rs2; rs1_used_id = t.u1; rs2_used_id = t.u2;
    rd_id = t.rd; reg_we_id = t.we; load_inst_id = t.ld; mem_inst_id = t.mem;
    branch_taken_ex = t.br; dmem_ready = t.rdy;
  endtask

  vec_t tab[$];
  vec_t rv;

  initial begin
    // r,rs1,rs2,u1,u2,rd,we,ld,mem,br,rdy | sif,sid,bub,fl,rdex,weex,cnt
    tab.push_back(v(0, 0,0,0,0, 0,0,0,0, 0,1,  0,0,1,0, 0,0,0));   // reset state
    tab.push_back(v(1, 0,0,0,0, 5,1,1,1, 0,1,  0,0,0,0, 0,0,0));   // ID: lw x5
    tab.push_back(v(1, 5,0,1,0, 6,1,0,0, 0,1,  1,1,1,0, 5,1,0));   // add uses x5: load-use
    tab.push_back(v(1, 5,0,1,0, 6,1,0,0, 0,1,  0,0,0,0, 0,0,1));   // bubble in EX, no repeat
    tab.push_back(v(1, 6,0,1,0, 7,1,0,0, 0,1,  0,0,0,0, 6,1,1));   // ALU dep: forwarded
    tab.push_back(v(1, 0,7,0,1, 0,1,1,1, 0,1,  0,0,0,0, 7,1,1));   // ALU dep on rs2; ID lw x0
    tab.push_back(v(1, 0,0,1,1, 9,0,0,1, 0,1,  0,0,0,0, 0,1,1));   // reads x0 behind lw x0
    tab.push_back(v(1, 0,0,0,0,10,1,0,0, 0,0,  1,1,0,0, 9,0,1));   // store waits: cycle 1
    tab.push_back(v(1, 0,0,0,0,10,1,0,0, 0,0,  1,1,0,0, 9,0,2));   // cycle 2
    tab.push_back(v(1, 0,0,0,0,10,1,0,0, 0,0,  1,1,0,0, 9,0,3));   // cycle 3
    tab.push_back(v(1, 0,0,0,0,10,1,0,0, 0,1,  0,0,0,0, 9,0,4));   // ready: advance
    tab.push_back(v(1, 0,0,0,0, 8,1,1,1, 0,1,  0,0,0,0,10,1,4));   // ID: lw x8
    tab.push_back(v(1, 0,8,0,1,11,1,0,0, 1,1,  0,0,1,1, 8,1,4));   // branch beats load-use
    tab.push_back(v(1, 0,0,0,0, 0,0,0,1, 0,1,  0,0,0,0, 0,0,4));   // ID: store
    tab.push_back(v(1, 0,0,0,0,12,1,0,0, 1,0,  1,1,0,0, 0,0,4));   // branch held while waiting
    tab.push_back(v(1, 0,0,0,0,12,1,0,0, 1,0,  1,1,0,0, 0,0,5));
    tab.push_back(v(1, 0,0,0,0,12,1,0,0, 1,1,  0,0,1,1, 0,0,6));   // flush on ready cycle
    tab.push_back(v(1, 0,0,0,0, 5,1,1,1, 0,1,  0,0,0,0, 0,0,6));   // ID: lw x5
    tab.push_back(v(1, 5,0,1,0, 6,1,0,0, 0,0,  1,1,0,0, 5,1,6));   // mem wait beats load-use
    tab.push_back(v(0, 5,0,1,0, 6,1,0,0, 0,0,  0,0,1,0, 5,1,7));   // reset mid-wait
    tab.push_back(v(1, 5,0,1,0, 6,1,0,0, 0,0,  0,0,0,0, 0,0,0));   // access abandoned
    tab.push_back(v(1, 0,0,0,0, 4,1,1,1, 0,1,  0,0,0,0, 6,1,0));   // ID: lw x4
    tab.push_back(v(1, 4,0,1,0, 6,1,0,0, 0,0,  1,1,0,0, 4,1,0));   // lw x4 waits
    tab.push_back(v(1, 4,0,1,0, 6,1,0,0, 0,1,  0,0,0,0, 4,1,1));   // ready cycle: no load-use

    // Two reset edges before anything is checked.
    drive(v(0, 0,0,0,0, 0,0,0,0, 0,1, 0,0,0,0, 0,0,0));
    tick();
    tick();

    for (int i = 0; i < tab.size(); i++) begin
      drive(tab[i]);
      #2;
      chk_all($sformatf("row%0d", i), tab[i].sif, tab[i].sid, tab[i].bub, tab[i].fl,
              tab[i].rdex, tab[i].weex, tab[i].cnt);
      tick();
    end

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      int kind;
      kind = $urandom_range(0, 2);  // 0 ALU, 1 load, 2 store
      rv = v(($urandom_range(0, 99) < 3) ? 0 : 1,
             $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 7), (kind == 2) ? 0 : $urandom_range(0, 1),
             (kind == 1) ? 1 : 0, (kind != 0) ? 1 : 0,
             ($urandom_range(0, 6) == 0) ? 1 : 0,
             ($urandom_range(0, 3) != 0) ? 1 : 0,
             0,0,0,0,0,0,0);
      drive(rv);
      #2;
      model_eval();
      chk_all($sformatf("rnd%0d", n), e_sif, e_sid, e_bub, e_fl, m_rd, m_we, 16'(m_cnt));
      tick();
    end

    // Saturation: a store that never completes.
    drive(v(0, 0,0,0,0, 0,0,0,0, 0,1, 0,0,0,0, 0,0,0));
    tick();
    drive(v(1, 0,0,0,0, 3,0,0,1, 0,1, 0,0,0,0, 0,0,0));
    tick();
    drive(v(1, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0,0, 0,0,0));
    for (int i = 0; i < 65540; i++) begin
      if (i == 0 || i == 65534 || i == 65535 || i == 65539) begin
        #2;
        chk($sformatf("sat%0d.stall_if", i), 32'(stall_if), 32'd1);
        chk($sformatf("sat%0d.stall_cnt", i), 32'(stall_cnt), (i > 65535) ? 32'd65535 : 32'(i));
      end
      tick();
    end
    #2;
    chk("sat_end.stall_cnt", 32'(stall_cnt), 32'hFFFF);
    chk("sat_end.rd_ex", 32'(rd_ex), 32'd3);

    // Reset while still waiting on the store.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #2;
    chk_all("after_rst", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ama_riscv_hazard_unit.md
AMA_RISCV_HAZARD_UNIT -- requirements
Module: ama_riscv_hazard_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-004 Port rs1_id / rs2_id, input, 5 bits each: source register indices of the instruction in ID.
REQ-005 Port rs1_used_id / rs2_used_id, input, 1 bit each: ID instruction reads rs1 / rs2.
REQ-006 Port rd_id, input, 5 bits: destination register index of the ID instruction.
REQ-007 Port reg_we_id, input, 1 bit: ID instruction writes rd.
REQ-008 Port load_inst_id, input, 1 bit: ID instruction is a load.
REQ-009 Port mem_inst_id, input, 1 bit: ID instruction is a load or a store.
REQ-010 Port branch_taken_ex, input, 1 bit: the EX instruction redirects the PC.
REQ-011 Port dmem_ready, input, 1 bit: data memory accepts or completes the EX access this cycle.
REQ-012 Port rd_ex, output, 5 bits: tracked EX destination index; feeds operand forwarding.
REQ-013 Port reg_we_ex, output, 1 bit: tracked EX write enable; feeds operand forwarding.
REQ-014 Port stall_if / stall_id, output, 1 bit each: hold PC / hold the IF-ID register.
REQ-015 Port bubble_ex, output, 1 bit: load a NOP into EX on the next edge.
REQ-016 Port flush_id, output, 1 bit: kill the instruction in ID.
REQ-017 Port stall_cnt, output, 16 bits: saturating count of cycles with stall_if high.

Function
REQ-018 The block SHALL hold EX tracking registers rd_ex, reg_we_ex, load_ex, and mem_ex.
REQ-019 EX tracking registers SHALL capture rd_id, reg_we_id, load_inst_id, and mem_inst_id on an edge when stall_id=0 and bubble_ex=0.
REQ-020 EX tracking registers SHALL clear to 0 on an edge when bubble_ex=1.
REQ-021 EX tracking registers SHALL hold their value when in MEM_WAIT.
REQ-022 The FSM SHALL have two states: RUN and MEM_WAIT.
REQ-023 mem_busy is defined as mem_ex & ~dmem_ready.
REQ-024 load_use is defined as: state RUN & load_ex & reg_we_ex & rd_ex≠0 & ((rs1_used_id & rs1_id==rd_ex) | (rs2_used_id & rs2_id==rd_ex)).
REQ-025 RUN -> MEM_WAIT when mem_busy=1.
REQ-026 MEM_WAIT -> RUN on the first cycle with dmem_ready=1.
REQ-027 All outputs except rd_ex, reg_we_ex, and stall_cnt SHALL be combinational from state, tracking registers, and current inputs, with zero-cycle latency.
REQ-028 Priority SHALL be mem_busy > branch_taken_ex > load_use.
REQ-029 When mem_busy=1 (in either state): stall_if=1, stall_id=1, bubble_ex=0, flush_id=0.
REQ-030 On the dmem_ready cycle with branch_taken_ex=1: flush_id=1, bubble_ex=1, stall_if=0, stall_id=0.
REQ-031 A branch held during MEM_WAIT SHALL be flushed only on the cycle dmem_ready arrives, never earlier.
REQ-032 When branch_taken_ex=1 and mem_busy=0: flush_id=1, bubble_ex=1, stall_if=0, stall_id=0, and load_use SHALL be ignored.
REQ-033 When load_use=1 (mem_busy=0, branch_taken_ex=0): stall_if=1, stall_id=1, bubble_ex=1, flush_id=0, for exactly one cycle.
REQ-034 After a load_use bubble, load_ex=0 on the next cycle, so the stall SHALL NOT repeat.
REQ-035 A source index of 0 SHALL never cause a stall.
REQ-036 A dependency on a non-load EX instruction SHALL NOT stall; operand forwarding covers it.
REQ-037 stall_cnt SHALL increment by 1 per cycle with stall_if=1 and saturate at 16'hFFFF, with no wrap.

Reset
REQ-038 When rst_n=0 at an edge: state=RUN, rd_ex=0, reg_we_ex=0, load_ex=0, mem_ex=0, stall_cnt=0.
REQ-039 While rst_n=0, stall_if, stall_id, and flush_id SHALL be 0 and bubble_ex SHALL be 1.
REQ-040 Reset asserted in MEM_WAIT SHALL return to RUN on that edge, abandoning the pending access.

Verification
REQ-041 Load x5 in EX, ID add reading rs1=x5 -> one cycle with stall_if=stall_id=bubble_ex=1; next cycle all 0 and reg_we_ex=0; stall_cnt=1.
REQ-042 Load x0 in EX, ID reading x0 -> no stall; ALU (non-load) write x7 in EX, ID reading x7 -> no stall.
REQ-043 Store in EX, dmem_ready low for 3 cycles -> state MEM_WAIT, stall_if=1 for 3 cycles, rd_ex held; returns to RUN on the 4th cycle; stall_cnt=3.
REQ-044 branch_taken_ex=1 together with load_use -> flush_id=1, bubble_ex=1, stall_if=0.
REQ-045 branch_taken_ex=1 during a 2-cycle MEM_WAIT -> flush_id=0 while waiting; flush_id=1 on the ready cycle.
REQ-046 Force 65540 stall cycles -> stall_cnt=16'hFFFF; rst_n=0 mid-MEM_WAIT -> state RUN, all counters and tracking registers 0 after one edge.
